// File: rtl/axi_burst_master.sv
// AXI4 INCR burst master: one outstanding write or read at a time, a one-deep
// registered W stage, a registered read-beat stream and a done pulse that
// carries the response.
module axi_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  // command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  // write beat stream
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  // read beat stream
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  // status
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              len_err,
  output logic              timeout,
  // AW channel
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  // W channel
  output logic [DATA_W-1:0] WDATA,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  // B channel
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  // AR channel
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  // R channel
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  localparam int SIZE_V = $clog2(DATA_W / 8);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [8:0]        beat_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wload;

  // Address/len are shared by both directions; the slave does the INCR.
  assign AWADDR  = addr_q;
  assign ARADDR  = addr_q;
  assign AWLEN   = len_q;
  assign ARLEN   = len_q;
  assign AWSIZE  = 3'(SIZE_V);
  assign ARSIZE  = 3'(SIZE_V);
  assign AWBURST = 2'b01;
  assign ARBURST = 2'b01;

  // Handshake-side readies decoded from registered state.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    wr_ready  = (state == S_W) && (!WVALID || WREADY) && (beat_cnt <= {1'b0, len_q});
    wload     = wr_valid && wr_ready;
  end

  // Transaction FSM with all channel outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      WDATA     <= '0;
      WLAST     <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      done_resp <= '0;
      len_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;

      // Wait counter; every state change below overrides it back to zero.
      if (state != S_IDLE) begin
        if (wait_cnt == TO_VAL) timeout  <= 1'b1;
        else                    wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            timeout   <= 1'b0;
            len_err   <= 1'b0;
            done_resp <= '0;
            if (cmd_write) begin
              AWVALID <= 1'b1;
              state   <= S_AW;
            end else begin
              ARVALID <= 1'b1;
              state   <= S_AR;
            end
          end
        end

        S_AW: begin
          if (AWREADY) begin
            AWVALID  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_W;
          end
        end

        S_W: begin
          if (wload) begin
            WDATA    <= wr_data;
            WVALID   <= 1'b1;
            WLAST    <= (beat_cnt == {1'b0, len_q});
            beat_cnt <= beat_cnt + 9'd1;
          end else if (WVALID && WREADY) begin
            WVALID <= 1'b0;
          end
          // No load can coincide with the last handshake: issued is len+1 by then.
          if (WVALID && WREADY && WLAST) begin
            WVALID   <= 1'b0;
            WLAST    <= 1'b0;
            BREADY   <= 1'b1;
            wait_cnt <= '0;
            state    <= S_B;
          end
        end

        S_B: begin
          if (BVALID) begin
            done_resp <= BRESP;
            done      <= 1'b1;
            BREADY    <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_IDLE;
          end
        end

        S_AR: begin
          if (ARREADY) begin
            ARVALID  <= 1'b0;
            RREADY   <= 1'b1;
            wait_cnt <= '0;
            state    <= S_R;
          end
        end

        S_R: begin
          if (RVALID) begin
            rd_data  <= RDATA;
            rd_valid <= 1'b1;
            rd_last  <= RLAST;
            if (RRESP > done_resp) done_resp <= RRESP;
            // Saturate so a runaway slave cannot wrap the count back onto len.
            if (beat_cnt != 9'h1FF) beat_cnt <= beat_cnt + 9'd1;
            if (RLAST) begin
              len_err  <= len_err | (beat_cnt != {1'b0, len_q});
              done     <= 1'b1;
              RREADY   <= 1'b0;
              wait_cnt <= '0;
              state    <= S_IDLE;
            end else if (beat_cnt == {1'b0, len_q}) begin
              len_err <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: a transaction table run against a small
// in-bench AXI slave with a word memory, plus hand sequences for timeout and
// mid-burst reset.
module tb_axi_burst_master;

  localparam int TO = 64;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        done;
  logic [1:0]  done_resp;
  logic        len_err;
  logic        timeout;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  axi_burst_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .len_err(len_err), .timeout(timeout),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [256];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] base;       // write data base / expected read data base
    int          wmode;      // 0: WREADY always 1, 1: WREADY toggles
    logic [1:0]  resp_in;    // BRESP, or RRESP on err_beat
    int          rlast_beat; // beat index on which the slave raises RLAST
    int          err_beat;   // beat index carrying resp_in (-1: none)
    logic [1:0]  exp_resp;
    bit          exp_len_err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle budget expired at %0t", name, $time);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base,
                          input int wmode, input logic [1:0] bresp, input logic [1:0] exp_resp,
                          input int aw_delay);
    int  aw_wait;
    int  hs;
    int  ld;
    bit  aw_done;
    bit  b_pend;
    bit  fin;
    bit  prev_stall;
    logic [31:0] prev_data;
    aw_wait = 0; hs = 0; ld = 0; aw_done = 0; b_pend = 0; fin = 0; prev_stall = 0;
    prev_data = '0;
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    WREADY = 1'b0;
    for (int cyc = 0; cyc < aw_delay + 300; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        cmd_valid = 1'b0;
        chk("timeout_clr_wr", {31'd0, timeout}, 32'd0);
        chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      end
      if (b_pend) begin
        chk("wr_done", {31'd0, done}, 32'd1);
        chk("wr_done_resp", {30'd0, done_resp}, {30'd0, exp_resp});
        chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("w_beats", hs, int'(len) + 1);
        fin = 1;
        break;
      end
      if (!aw_done) begin
        if (aw_delay > TO && aw_wait == TO - 2)
          chk("timeout_early", {31'd0, timeout}, 32'd0);
        if (aw_delay > TO && aw_wait == aw_delay) begin
          chk("timeout_set", {31'd0, timeout}, 32'd1);
          chk("awvalid_held", {31'd0, AWVALID}, 32'd1);
        end
      end
      AWREADY  = !aw_done && (aw_wait >= aw_delay);
      WREADY   = (wmode == 0) ? 1'b1 : ~WREADY;
      wr_valid = (ld <= int'(len));
      wr_data  = base + ld;
      BVALID   = (hs == int'(len) + 1);
      BRESP    = bresp;
      #1;
      if (!aw_done && AWVALID && AWREADY) begin
        chk("awaddr", AWADDR, addr);
        chk("awlen", {24'd0, AWLEN}, {24'd0, len});
        chk("awsize_burst", {27'd0, AWSIZE, AWBURST}, {27'd0, 3'd2, 2'b01});
        aw_done = 1;
      end
      if (!aw_done) aw_wait++;
      if (prev_stall) chk("wdata_hold", WDATA, prev_data);
      prev_stall = WVALID && !WREADY;
      prev_data  = WDATA;
      if (WVALID && WREADY) begin
        chk("wdata", WDATA, base + hs);
        chk("wlast", {31'd0, WLAST}, {31'd0, hs == int'(len)});
        mem[(int'(addr >> 2) + hs) & 255] = WDATA;
        hs++;
      end
      if (wr_valid && wr_ready) ld++;
      if (BVALID && BREADY) b_pend = 1;
    end
    if (!fin) bound_fail("write_done");
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done_pulse", {31'd0, done}, 32'd0);
    chk("wvalid_low", {31'd0, WVALID}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base,
                         input int rlast_beat, input int err_beat, input logic [1:0] err_resp,
                         input logic [1:0] exp_resp, input bit exp_len_err);
    int  beat;
    bit  r_go;
    bit  r_pend;
    bit  last_sent;
    bit  fin;
    beat = 0; r_go = 0; r_pend = 0; last_sent = 0; fin = 0;
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        cmd_valid = 1'b0;
        chk("timeout_clr_rd", {31'd0, timeout}, 32'd0);
      end
      if (r_pend) begin
        chk("rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("rd_data", rd_data, base + beat - 1);
        chk("rd_last", {31'd0, rd_last}, {31'd0, last_sent});
        if (last_sent) begin
          chk("rd_done", {31'd0, done}, 32'd1);
          chk("rd_len_err", {31'd0, len_err}, {31'd0, exp_len_err});
          chk("rd_done_resp", {30'd0, done_resp}, {30'd0, exp_resp});
          chk("rd_cmd_ready", {31'd0, cmd_ready}, 32'd1);
          fin = 1;
          break;
        end
        r_pend = 0;
      end
      ARREADY = ARVALID;
      RVALID  = r_go && !last_sent;
      RDATA   = mem[(int'(addr >> 2) + beat) & 255];
      RLAST   = (beat == rlast_beat);
      RRESP   = (beat == err_beat) ? err_resp : 2'b00;
      #1;
      if (ARVALID && ARREADY) begin
        chk("araddr", ARADDR, addr);
        chk("arlen", {24'd0, ARLEN}, {24'd0, len});
        chk("arsize_burst", {27'd0, ARSIZE, ARBURST}, {27'd0, 3'd2, 2'b01});
        r_go = 1;
      end
      if (RVALID && RREADY) begin
        r_pend    = 1;
        last_sent = RLAST;
        beat++;
      end
    end
    if (!fin) bound_fail("read_done");
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    @(negedge clk);
    chk("rd_done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int k;
    int hs;
    bit reached;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + i;
    //           wr addr   len base    wm resp   rl  eb  exp    le
    vecs[0] = '{1, 'h10, 3, 'hA0, 0, 2'b00, 0, -1, 2'b00, 0};
    vecs[1] = '{1, 'h10, 3, 'hA0, 1, 2'b00, 0, -1, 2'b00, 0};
    vecs[2] = '{0, 'h10, 3, 'hA0, 0, 2'b00, 3, -1, 2'b00, 0};
    vecs[3] = '{0, 'h10, 3, 'hA0, 0, 2'b10, 1,  0, 2'b10, 1};
    vecs[4] = '{1, 'h40, 0, 'hB0, 1, 2'b10, 0, -1, 2'b10, 0};
    vecs[5] = '{0, 'h40, 0, 'hB0, 0, 2'b00, 0, -1, 2'b00, 0};
    vecs[6] = '{0, 'h10, 1, 'hA0, 0, 2'b01, 3,  2, 2'b01, 1};
    vecs[7] = '{1, 'h60, 7, 'hC0, 1, 2'b11, 0, -1, 2'b11, 0};
    vecs[8] = '{0, 'h60, 7, 'hC0, 0, 2'b11, 7,  5, 2'b11, 0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BRESP = '0; BVALID = 1'b0;
    ARREADY = 1'b0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valids", {26'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY, rd_valid}, 32'd0);
    chk("rst_status", {29'd0, done, len_err, timeout}, 32'd0);
    chk("rst_addr_len", AWADDR | {24'd0, AWLEN}, 32'd0);
    chk("rst_size_burst", {22'd0, AWSIZE, AWBURST, ARSIZE, ARBURST}, {22'd0, 3'd2, 2'b01, 3'd2, 2'b01});
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].wr)
        do_write(vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].wmode,
                 vecs[v].resp_in, vecs[v].exp_resp, 0);
      else
        do_read(vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].rlast_beat,
                vecs[v].err_beat, vecs[v].resp_in, vecs[v].exp_resp, vecs[v].exp_len_err);
    end

    // AWREADY withheld past the timeout limit; the write must still finish.
    do_write('h20, 1, 'hD0, 0, 2'b00, 2'b00, TO + 5);
    chk("timeout_sticky", {31'd0, timeout}, 32'd1);
    do_read('h20, 1, 'hD0, 1, -1, 2'b00, 2'b00, 0);

    // Reset while the second W beat is in the output register.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 'h80; cmd_len = 3;
    @(negedge clk);
    cmd_valid = 1'b0; AWREADY = 1'b1; WREADY = 1'b1;
    k = 0; hs = 0; reached = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hE0 + k;
      #1;
      if (WVALID && WREADY) hs++;
      if (wr_valid && wr_ready) k++;
      if (hs == 1) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    if (!reached) bound_fail("reset_seq_w");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wvalid", {31'd0, WVALID}, 32'd0);
    chk("rst_mid_valids", {26'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY, rd_valid}, 32'd0);
    chk("rst_mid_done_wlast", {30'd0, done, WLAST}, 32'd0);
    chk("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    wr_valid = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    do_read('h10, 3, 'hA0, 3, -1, 2'b00, 2'b00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
